alu_operand_loader: RTL and testbench

Upstream front-end for the 4-bit ALU. It accepts operand A, operand B and an opcode as three successive 4-bit nibbles, each qualified by a slow, asynchronous strobe from the pads. It registers the three values and drives them to the ALU as stable operands, then captures the ALU's 8-bit result into a held output register. It also flags protocol errors and abandoned loads.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_operand_loader_if.sv | 27 ++
 rtl/strobe_sync_edge.sv | 42 ++++
 rtl/alu_operand_loader.sv | 120 ++++++++++++
 tb/tb_alu_operand_loader.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its operand loader front-end:
// datapath widths, loader FSM states and the opcode map.
package alu_pkg;

  localparam int NIB_W = 4;
  localparam int OP_W  = 3;
  localparam int RES_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    ISSUE   = 2'd3
  } loader_state_e;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR = 3'b110;
  localparam logic [OP_W-1:0] OP_NOT = 3'b111;

  // Opcode nibbles with the top bit set are reserved and rejected by the loader.
  function automatic logic is_reserved_op(input logic [NIB_W-1:0] nib);
    return nib[NIB_W-1];
  endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Pad-side nibble strobe plus the operand/result bus between the loader and the ALU.
interface alu_operand_loader_if;
  import alu_pkg::*;

  logic              in_valid;
  logic [NIB_W-1:0]  in_data;
  logic [NIB_W-1:0]  out_a;
  logic [NIB_W-1:0]  out_b;
  logic [OP_W-1:0]   out_op;
  logic              issue;
  logic [RES_W-1:0]  alu_result;
  logic [RES_W-1:0]  result_q;
  logic              result_valid;
  logic              busy;
  logic              err;

  modport master (
    input  in_valid, in_data, alu_result,
    output out_a, out_b, out_op, issue, result_q, result_valid, busy, err
  );

  modport slave (
    output in_valid, in_data, alu_result,
    input  out_a, out_b, out_op, issue, result_q, result_valid, busy, err
  );

endinterface

// File: rtl/strobe_sync_edge.sv
// Synchronizes the asynchronous nibble strobe and emits a one-cycle accept
// pulse on each synced rising edge, but only once the line has been seen low.
module strobe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic accept
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] fill_reg;
  logic                   prev_reg;
  logic                   armed_reg;
  logic                   accept_reg;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];
  assign accept = accept_reg;

  // fill_reg tracks when the chain's last stage holds a real pin sample rather
  // than its reset zero, so a strobe held high through reset never arms us.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg   <= '0;
      fill_reg   <= '0;
      prev_reg   <= 1'b0;
      armed_reg  <= 1'b0;
      accept_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], in_valid};
      fill_reg   <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
      prev_reg   <= synced;
      if (fill_reg[SYNC_STAGES-1] && !synced) begin
        armed_reg <= 1'b1;
      end
      accept_reg <= armed_reg && synced && !prev_reg;
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Collects A, B and opcode nibbles, presents them to the ALU as stable operands,
// captures the ALU result, and flags reserved opcodes and abandoned loads.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  alu_operand_loader_if.master bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic              accept;
  logic              timeout;
  loader_state_e     state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [NIB_W-1:0]  a_reg;
  logic [NIB_W-1:0]  b_reg;
  logic [OP_W-1:0]   op_reg;
  logic [RES_W-1:0]  result_reg;
  logic              result_valid_reg;
  logic              err_reg;

  strobe_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .accept   (accept)
  );

  // Fires on the enabled cycle whose increment would reach TIMEOUT_CYCLES.
  assign timeout = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      op_reg           <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      err_reg          <= 1'b0;
    end else if (ena) begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (accept) begin
            a_reg            <= bus.in_data;
            err_reg          <= 1'b0;
            result_valid_reg <= 1'b0;
            state_reg        <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (accept) begin
            b_reg     <= bus.in_data;
            cnt_reg   <= '0;
            state_reg <= WAIT_OP;
          end else if (timeout) begin
            cnt_reg   <= '0;
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_OP: begin
          if (accept) begin
            cnt_reg <= '0;
            if (is_reserved_op(bus.in_data)) begin
              err_reg   <= 1'b1;
              state_reg <= IDLE;
            end else begin
              op_reg    <= bus.in_data[OP_W-1:0];
              state_reg <= ISSUE;
            end
          end else if (timeout) begin
            cnt_reg   <= '0;
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ISSUE: begin
          cnt_reg          <= '0;
          result_reg       <= bus.alu_result;
          result_valid_reg <= 1'b1;
          state_reg        <= IDLE;
          // A strobe landing on the issue cycle cannot start a new load.
          if (accept) begin
            err_reg <= 1'b1;
          end
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_a        = a_reg;
  assign bus.out_b        = b_reg;
  assign bus.out_op       = op_reg;
  assign bus.issue        = ena && (state_reg == ISSUE);
  assign bus.result_q     = result_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.err          = err_reg;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: behavioural ALU on the bus, scenario tasks with
// inline comparisons against expectations derived from the nibbles sent.
module tb_alu_operand_loader;
  import alu_pkg::*;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;

  alu_operand_loader_if bus();

  alu_operand_loader #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc            = 0;
  int checks         = 0;
  int errors         = 0;
  int issue_cnt      = 0;
  int last_issue_cyc = -1;
  int last_rise      = 0;
  logic [2:0] m_op;
  logic [7:0] m_res;

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      OP_ADD:  return 8'(a) + 8'(b);
      OP_SUB:  return 8'(a) - 8'(b);
      OP_AND:  return {4'h0, a & b};
      OP_OR:   return {4'h0, a | b};
      OP_XOR:  return {4'h0, a ^ b};
      OP_SHL:  return 8'(a) << b[1:0];
      OP_SHR:  return 8'(a) >> b[1:0];
      default: return {4'h0, ~a};
    endcase
  endfunction

  always_comb bus.alu_result = alu_fn(bus.out_a, bus.out_b, bus.out_op);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.issue === 1'b1) begin
      issue_cnt      <= issue_cnt + 1;
      last_issue_cyc <= cyc;
    end
  end

  task automatic pulse(input logic [3:0] d, input int hi, input int lo);
    @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    last_rise    = cyc;
    repeat (hi) @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'($urandom);
    bus.in_data  = 4'($urandom);
    ena          = 1'($urandom);
    repeat (3) @(negedge clk);
    checks++; if (bus.out_a !== 4'h0) begin errors++; $display("FAIL reset_out_a got %h exp 0", bus.out_a); end
    checks++; if (bus.out_b !== 4'h0) begin errors++; $display("FAIL reset_out_b got %h exp 0", bus.out_b); end
    checks++; if (bus.out_op !== 3'h0) begin errors++; $display("FAIL reset_out_op got %h exp 0", bus.out_op); end
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL reset_issue got %b exp 0", bus.issue); end
    checks++; if (bus.result_q !== 8'h00) begin errors++; $display("FAIL reset_result_q got %h exp 00", bus.result_q); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got %b exp 0", bus.result_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
    bus.in_valid = 1'b0;
    ena          = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", bus.busy); end
    checks++; if (issue_cnt != 0) begin errors++; $display("FAIL reset_idle_issue got %0d exp 0", issue_cnt); end
    $display("reset done");
  endtask

  task automatic test_basic();
    int c0;
    int base;
    base = issue_cnt;
    pulse(4'h3, 4, 4);
    pulse(4'h5, 4, 4);
    checks++; if (bus.out_a !== 4'h3) begin errors++; $display("FAIL basic_out_a got %h exp 3", bus.out_a); end
    checks++; if (bus.out_b !== 4'h5) begin errors++; $display("FAIL basic_out_b got %h exp 5", bus.out_b); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_mid got %b exp 1", bus.busy); end
    @(negedge clk);
    bus.in_data  = 4'h0;
    bus.in_valid = 1'b1;
    c0 = cyc;
    repeat (3) @(negedge clk);
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL basic_issue_early got %b exp 0", bus.issue); end
    @(negedge clk);
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL basic_issue got %b exp 1", bus.issue); end
    checks++; if (bus.out_op !== OP_ADD) begin errors++; $display("FAIL basic_out_op got %h exp 0", bus.out_op); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL basic_rv_early got %b exp 0", bus.result_valid); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL basic_issue_width got %b exp 0", bus.issue); end
    checks++; if (bus.result_q !== 8'h08) begin errors++; $display("FAIL basic_result_q got %h exp 08", bus.result_q); end
    checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL basic_rv got %b exp 1", bus.result_valid); end
    repeat (4) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", bus.busy); end
    checks++; if (issue_cnt - base != 1) begin errors++; $display("FAIL basic_issue_count got %0d exp 1", issue_cnt - base); end
    checks++; if (last_issue_cyc != c0 + SYNC + 2) begin errors++; $display("FAIL basic_issue_latency got %0d exp %0d", last_issue_cyc - c0, SYNC + 2); end
    m_op = OP_ADD; m_res = 8'h08;
    $display("load a=3 b=5 op=0 result_q=%h", bus.result_q);
  endtask

  task automatic test_reserved();
    int base;
    base = issue_cnt;
    pulse(4'h9, 4, 4);
    pulse(4'h6, 4, 4);
    pulse(4'hA, 4, 4);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL rsv_err got %b exp 1", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rsv_busy got %b exp 0", bus.busy); end
    checks++; if (issue_cnt != base) begin errors++; $display("FAIL rsv_issue got %0d exp %0d", issue_cnt, base); end
    checks++; if (bus.result_q !== m_res) begin errors++; $display("FAIL rsv_result_q got %h exp %h", bus.result_q, m_res); end
    checks++; if (bus.out_op !== m_op) begin errors++; $display("FAIL rsv_out_op got %h exp %h", bus.out_op, m_op); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL rsv_rv got %b exp 0", bus.result_valid); end
    $display("load a=9 b=6 op=a reserved err=%b", bus.err);
    pulse(4'h7, 4, 4);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rsv_err_clear got %b exp 0", bus.err); end
    pulse(4'h2, 4, 4);
    pulse(4'h4, 4, 4);
    checks++; if (bus.result_q !== 8'h05) begin errors++; $display("FAIL rsv_next_result got %h exp 05", bus.result_q); end
    m_op = OP_XOR; m_res = 8'h05;
    $display("load a=7 b=2 op=4 result_q=%h", bus.result_q);
  endtask

  task automatic test_timeout();
    int c0;
    // Abandoned after A: times out 16 enabled cycles after the FSM takes A.
    pulse(4'h1, 4, 4);
    c0 = last_rise;
    wait_until(c0 + SYNC + 2 + TMO - 1);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL tmo_busy_before got %b exp 1", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL tmo_err_before got %b exp 0", bus.err); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_busy_after got %b exp 0", bus.busy); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL tmo_err_after got %b exp 1", bus.err); end
    checks++; if (bus.out_a !== 4'h1) begin errors++; $display("FAIL tmo_out_a got %h exp 1", bus.out_a); end
    $display("load a=1 abandoned err=%b", bus.err);
    // B taken 15 cycles after A: no timeout.
    pulse(4'h2, 4, 4);
    c0 = last_rise;
    wait_until(c0 + 14);
    pulse(4'h6, 4, 4);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL tmo15_busy got %b exp 1", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL tmo15_err got %b exp 0", bus.err); end
    pulse(4'h1, 4, 4);
    checks++; if (bus.result_q !== 8'hFC) begin errors++; $display("FAIL tmo15_result got %h exp fc", bus.result_q); end
    $display("load a=2 b=6 op=1 late_b result_q=%h", bus.result_q);
    // B lands on the very cycle the timeout would fire: accept wins.
    pulse(4'h4, 4, 4);
    c0 = last_rise;
    wait_until(c0 + 15);
    pulse(4'h9, 4, 4);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL tmo16_busy got %b exp 1", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL tmo16_err got %b exp 0", bus.err); end
    checks++; if (bus.out_b !== 4'h9) begin errors++; $display("FAIL tmo16_out_b got %h exp 9", bus.out_b); end
    pulse(4'h3, 4, 4);
    checks++; if (bus.result_q !== 8'h0D) begin errors++; $display("FAIL tmo16_result got %h exp 0d", bus.result_q); end
    $display("load a=4 b=9 op=3 coincident_b result_q=%h", bus.result_q);
  endtask

  task automatic test_enable();
    int base;
    pulse(4'hD, 4, 4);
    pulse(4'h6, 4, 4);
    base = issue_cnt;
    ena = 1'b0;
    pulse(4'h2, 4, 4);
    repeat (20) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ena_busy got %b exp 1", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL ena_err got %b exp 0", bus.err); end
    checks++; if (issue_cnt != base) begin errors++; $display("FAIL ena_issue got %0d exp %0d", issue_cnt, base); end
    checks++; if (bus.out_op !== 3'h3) begin errors++; $display("FAIL ena_out_op_hold got %h exp 3", bus.out_op); end
    ena = 1'b1;
    pulse(4'h2, 4, 4);
    checks++; if (issue_cnt - base != 1) begin errors++; $display("FAIL ena_issue_after got %0d exp 1", issue_cnt - base); end
    checks++; if (bus.result_q !== 8'h04) begin errors++; $display("FAIL ena_result got %h exp 04", bus.result_q); end
    checks++; if (bus.out_op !== OP_AND) begin errors++; $display("FAIL ena_out_op got %h exp 2", bus.out_op); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL ena_err_after got %b exp 0", bus.err); end
    m_op = OP_AND; m_res = 8'h04;
    $display("load a=d b=6 op=2 after_freeze result_q=%h", bus.result_q);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [3:0] a, b, opn;
      logic       exp_rv, exp_err;
      int         base;
      a    = 4'($urandom);
      b    = 4'($urandom);
      opn  = 4'($urandom_range(0, 15));
      base = issue_cnt;
      pulse(a,   $urandom_range(3, 6), $urandom_range(3, 6));
      pulse(b,   $urandom_range(3, 6), $urandom_range(3, 6));
      pulse(opn, $urandom_range(3, 6), $urandom_range(3, 6));
      if (opn[3]) begin
        exp_err = 1'b1; exp_rv = 1'b0;
      end else begin
        exp_err = 1'b0; exp_rv = 1'b1;
        m_op    = opn[2:0];
        m_res   = alu_fn(a, b, opn[2:0]);
      end
      checks++; if (bus.out_a !== a) begin errors++; $display("FAIL rnd%0d_out_a got %h exp %h", i, bus.out_a, a); end
      checks++; if (bus.out_b !== b) begin errors++; $display("FAIL rnd%0d_out_b got %h exp %h", i, bus.out_b, b); end
      checks++; if (bus.out_op !== m_op) begin errors++; $display("FAIL rnd%0d_out_op got %h exp %h", i, bus.out_op, m_op); end
      checks++; if (bus.result_q !== m_res) begin errors++; $display("FAIL rnd%0d_result_q got %h exp %h", i, bus.result_q, m_res); end
      checks++; if (bus.result_valid !== exp_rv) begin errors++; $display("FAIL rnd%0d_rv got %b exp %b", i, bus.result_valid, exp_rv); end
      checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL rnd%0d_err got %b exp %b", i, bus.err, exp_err); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy got %b exp 0", i, bus.busy); end
      checks++; if (issue_cnt - base != (opn[3] ? 0 : 1)) begin errors++; $display("FAIL rnd%0d_issue got %0d exp %0d", i, issue_cnt - base, opn[3] ? 0 : 1); end
      $display("load a=%h b=%h op=%h result_q=%h err=%b", a, b, opn, bus.result_q, bus.err);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse(4'h7, 4, 4);
    pulse(4'hC, 4, 4);
    @(negedge clk);
    bus.in_data  = 4'h4;
    bus.in_valid = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    checks++; if (bus.out_a !== 4'h0) begin errors++; $display("FAIL rstmid_out_a got %h exp 0", bus.out_a); end
    checks++; if (bus.out_b !== 4'h0) begin errors++; $display("FAIL rstmid_out_b got %h exp 0", bus.out_b); end
    checks++; if (bus.result_q !== 8'h00) begin errors++; $display("FAIL rstmid_result_q got %h exp 00", bus.result_q); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_held_busy got %b exp 0", bus.busy); end
    checks++; if (bus.out_a !== 4'h0) begin errors++; $display("FAIL rstmid_held_out_a got %h exp 0", bus.out_a); end
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    pulse(4'hB, 4, 4);
    checks++; if (bus.out_a !== 4'hB) begin errors++; $display("FAIL rstmid_reload_a got %h exp b", bus.out_a); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_reload_busy got %b exp 1", bus.busy); end
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL rstmid_issue got %b exp 0", bus.issue); end
    $display("load a=b after_reset busy=%b", bus.busy);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    m_op  = 3'h0;
    m_res = 8'h00;
    test_reset();
    test_basic();
    test_reserved();
    test_timeout();
    test_enable();
    test_random();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
